pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised pipeline register with per-stage valid/ready flow control; generalises the single enable register to DEPTH stages of DATA_W bits.
- Collapses bubbles, supports synchronous flush and reports occupancy.
- Sits between cache pipeline stages, e.g. tag lookup to data array, and on refill return paths.

Parameters:
- DATA_W, 32, payload width in bits (>=1).
- DEPTH, 2, number of register stages (>=1).
- CNT_W, $clog2(DEPTH+2), width of the occupancy count. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous discard of all held entries.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  chain accepts in_data this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  oldest entry presented.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  DATA_W  oldest entry payload.
- count  output  CNT_W  number of valid entries held.

Behaviour:
- Storage: stage i (0 = input end, DEPTH-1 = output end) holds v[i] and d[i].
- Reset (reset low, asynchronous):
  - all v[i]=0, all d[i]=0, count=0.
  - Hence out_valid=0 and out_data=0.
- Handshakes:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - in_valid must hold with stable in_data until accepted.
- Advance logic, evaluated from the output end back:
  - take[DEPTH-1] = v[DEPTH-1] & sink_ready.
  - take[i] = v[i] & load[i+1].
  - load[i] = ~v[i] | take[i].
  - in_ready = load[0] & ~flush.
- Bubble collapse: an empty stage always loads, even while downstream is stalled.
- Stage update on load[i]:
  - v[i] <= v[i-1], with in_valid & in_ready used for stage 0.
  - d[i] is written only when the incoming entry is valid; otherwise d[i] holds.
- Latency and throughput:
  - An entry accepted in cycle k gives out_valid in cycle k+DEPTH when unstalled.
  - Sustained throughput is 1 entry per cycle.
- Ordering is strict FIFO. Entries are never duplicated or dropped except by flush.
- count:
  - +1 on an input transfer, -1 on an output transfer, unchanged when both occur.
  - Never exceeds capacity: DEPTH, or DEPTH+1 with the optional feature.
- Full: all v=1 and out_ready=0 gives in_ready=0. Full with out_ready=1 still accepts: pass-through at full rate.
- Empty: out_valid=0 and out_data holds its last value. There is no combinational in->out bypass; minimum latency is DEPTH.
- Flush:
  - in_ready is forced to 0 in the flush cycle.
  - out_valid/out_data are still driven that cycle. A simultaneous output transfer counts as delivered.
  - Next edge: all valid bits clear and count becomes 0. d[] is not cleared.
- Reset mid-transfer: all in-flight entries are discarded. No handshake completes in a cycle where reset is low.
- Without the optional feature: sink_ready = out_ready, out_valid = v[DEPTH-1], out_data = d[DEPTH-1]. in_ready depends combinationally on out_ready.

Optional Feature:
- Macro: PIPE_REG_SKID_EN.
- Defined: one skid entry (skid_v, skid_d, reset 0) is added at the output.
  - sink_ready = ~skid_v, a registered signal, which breaks the out_ready->in_ready combinational path.
  - out_valid = skid_v | v[DEPTH-1].
  - out_data = skid_v ? skid_d : d[DEPTH-1].
  - Skid loads when take[DEPTH-1] & ~out_ready.
  - Skid clears on an output transfer while skid_v=1.
  - Capacity is DEPTH+1; latency is unchanged. Flush also clears skid_v.
- Undefined: no skid logic; behaviour is exactly as above.

Decomposition:
- Shared package/header (global_config.v):
  - RESET_ENABLE defined as 1'b0 for the active-low reset.
  - Clog2-based count-width helper.
  - PIPE_REG_SKID_EN default (undefined).
- Natural sub-module: pipe_reg_stage, one valid bit plus DATA_W payload with load/capture enables and async active-low reset, instantiated DEPTH times via generate.

Test Plan:
- Reset low for 3 cycles with in_valid=1 -> out_valid=0, out_data=0, count=0, no transfers; first accept only after release.
- DEPTH=2, out_ready=1, in_data 0x01..0x08 back-to-back -> out_data 0x01..0x08 in order, first out_valid 2 cycles after first accept, one per cycle, count steady at 2.
- out_ready=0, push 0xA5,0x5A -> count=2, in_ready=0; third in_valid stalls. Raise out_ready with in_valid held -> 0xA5 out and third entry accepted in the same cycle, count stays 2.
- Bubble: push 0x11, idle 3 cycles, push 0x22 while out_ready=0 -> both stages valid, count=2, order 0x11 then 0x22.
- Flush with count=2 and in_valid=1, out_ready=1 -> in_ready=0, entry at output delivered, count=0 next cycle, other entry never appears.
- PIPE_REG_SKID_EN, DEPTH=2: out_ready=0, push 3 entries -> count=3, in_ready=0. Check in_ready does not depend combinationally on out_ready (toggle out_ready mid-cycle, in_ready unchanged before the edge).

Source files
------------

// File: rtl/pipe_reg_chain_pkg.sv
// Shared constants for the pipeline register chain: reset level and count-width helper.
// PIPE_REG_SKID_EN is left undefined by default.
package pipe_reg_chain_pkg;

  localparam logic RESET_ENABLE = 1'b0;

  // Count must reach DEPTH+1 when the skid entry is present.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One chain stage: valid bit plus payload, loaded on load_i, payload captured only for valid entries.
module pipe_reg_stage
  import pipe_reg_chain_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready pipeline register with bubble collapse, flush and occupancy count.
// Define PIPE_REG_SKID_EN to add a registered skid entry that cuts the out_ready->in_ready path.
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  logic [DEPTH-1:0]  v, v_in, load, take;
  logic [DATA_W-1:0] d    [DEPTH];
  logic [DATA_W-1:0] d_in [DEPTH];
  logic              sink_ready;
  logic              in_xfer, out_xfer;
  logic [CNT_W-1:0]  count_q, count_d;

  // Ready ripples from the output end back so empty stages always load.
  always_comb begin
    take = '0;
    load = '0;
    take[DEPTH-1] = v[DEPTH-1] & sink_ready;
    load[DEPTH-1] = ~v[DEPTH-1] | take[DEPTH-1];
    for (int unsigned j = 1; j < DEPTH; j++) begin
      take[DEPTH-1-j] = v[DEPTH-1-j] & load[DEPTH-j];
      load[DEPTH-1-j] = ~v[DEPTH-1-j] | take[DEPTH-1-j];
    end
  end

  assign in_ready = load[0] & ~flush & (reset != RESET_ENABLE);
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign v_in[g] = in_xfer;
      assign d_in[g] = in_data;
    end else begin : g_body
      assign v_in[g] = v[g-1];
      assign d_in[g] = d[g-1];
    end

    pipe_reg_stage #(
      .DATA_W(DATA_W)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (flush),
      .load_i (load[g]),
      .valid_i(v_in[g]),
      .data_i (d_in[g]),
      .valid_o(v[g]),
      .data_o (d[g])
    );
  end

`ifdef PIPE_REG_SKID_EN
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_d_q, skid_d_d;

  assign sink_ready = ~skid_v_q;
  assign out_valid  = skid_v_q | v[DEPTH-1];
  assign out_data   = skid_v_q ? skid_d_q : d[DEPTH-1];

  // The last stage always drains into the skid when downstream stalls.
  always_comb begin
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    if (flush) begin
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      if (out_ready) skid_v_d = 1'b0;
    end else if (take[DEPTH-1] && !out_ready) begin
      skid_v_d = 1'b1;
      skid_d_d = d[DEPTH-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      skid_v_q <= 1'b0;
      skid_d_q <= '0;
    end else begin
      skid_v_q <= skid_v_d;
      skid_d_q <= skid_d_d;
    end
  end
`else
  assign sink_ready = out_ready;
  assign out_valid  = v[DEPTH-1];
  assign out_data   = d[DEPTH-1];
`endif

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (in_xfer && !out_xfer) begin
      count_d = count_q + 1'b1;
    end else if (!in_xfer && out_xfer) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain: queue-based reference model plus directed literal checks.
module tb_pipe_reg_chain;

  localparam int unsigned DW = 8;
  localparam int unsigned D  = 2;
  localparam int unsigned CW = $clog2(D + 2);
`ifdef PIPE_REG_SKID_EN
  localparam bit          SKID = 1'b1;
  localparam int unsigned CAP  = D + 1;
`else
  localparam bit          SKID = 1'b0;
  localparam int unsigned CAP  = D;
`endif

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;

  pipe_reg_chain #(
    .DATA_W(DW),
    .DEPTH (D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: FIFO of accepted entries; an entry is visible DEPTH cycles after acceptance.
  typedef struct {
    logic [DW-1:0] data;
    int unsigned   t;
  } ent_t;

  ent_t q[$];
  bit   acc      = 1'b0;
  bit   zero_out = 1'b1;

  always @(negedge clk) begin
    bit exp_ov, exp_ir;
    cyc++;
    if (!reset) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_count", count, 0);
      q.delete();
      zero_out = 1'b1;
      acc = 1'b0;
    end else begin
      exp_ov = (q.size() > 0) && (cyc >= q[0].t + D);
      exp_ir = !flush && ((q.size() < CAP) ||
                          (!SKID && q.size() == CAP && exp_ov && out_ready));
      check("in_ready", in_ready, exp_ir);
      check("out_valid", out_valid, exp_ov);
      check("count", count, q.size());
      if (exp_ov) check("out_data", out_data, q[0].data);
      else if (zero_out) check("out_data_idle", out_data, 0);
      acc = in_valid && exp_ir;
      if (exp_ov && out_ready) void'(q.pop_front());
      if (flush) q.delete();
      else if (acc) begin
        q.push_back('{data: in_data, t: cyc});
        zero_out = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] x);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = x;
    for (int n = 0; n < 20 && !done; n++) begin
      step();
      done = acc;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: got no accept, expected accept of 0x%0h", x);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h33;

    repeat (3) begin
      @(negedge clk); #1;
      check("lit_rst_count", count, 0);
      check("lit_rst_ovalid", out_valid, 0);
    end
    step();
    reset = 1'b1;
    @(negedge clk);
    check("lit_first_accept", in_ready, 1);
    step();
    in_valid = 1'b0;
    repeat (4) step();

    // Back-to-back stream with out_ready held high.
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      @(negedge clk);
      if (i <= 2) check("lit_stream_lat", out_valid, 0);
      else begin
        check("lit_stream_data", out_data, i - 2);
        check("lit_stream_count", count, 2);
        check("lit_stream_ir", in_ready, 1);
      end
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();

    // Full chain with downstream stalled.
    out_ready = 1'b0;
    push(8'hA5);
    push(8'h5A);
`ifdef PIPE_REG_SKID_EN
    push(8'h3C);
    in_valid = 1'b1; in_data = 8'h4B;
`else
    in_valid = 1'b1; in_data = 8'h3C;
`endif
    @(negedge clk);
    check("lit_full_count", count, CAP);
    check("lit_full_ir", in_ready, 0);
    step();
    check("lit_full_ir_hold", in_ready, 0);
    out_ready = 1'b1;
    #1;
`ifdef PIPE_REG_SKID_EN
    check("lit_skid_ir_hi", in_ready, 0);
    out_ready = 1'b0; #1;
    check("lit_skid_ir_lo", in_ready, 0);
    out_ready = 1'b1;
`else
    check("lit_pass_ir", in_ready, 1);
`endif
    @(negedge clk);
    check("lit_full_out", out_data, 8'hA5);
    check("lit_full_count2", count, CAP);
    for (int n = 0; n < 20 && in_valid; n++) begin
      step();
      if (acc) in_valid = 1'b0;
    end
    repeat (6) step();

    // Bubble collapse behind a stalled output.
    out_ready = 1'b0;
    push(8'h11);
    repeat (3) step();
    push(8'h22);
    @(negedge clk);
    check("lit_bubble_count", count, 2);
    check("lit_bubble_first", out_data, 8'h11);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("lit_bubble_out1", out_data, 8'h11);
    step();
    @(negedge clk);
    check("lit_bubble_out2", out_data, 8'h22);
    repeat (3) step();

    // Flush with two entries held and output being accepted.
    out_ready = 1'b0;
    push(8'h77);
    push(8'h88);
    in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("lit_flush_ir", in_ready, 0);
    check("lit_flush_out", out_data, 8'h77);
    check("lit_flush_ov", out_valid, 1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk); #1;
    check("lit_flush_count", count, 0);
    check("lit_flush_model", q.size(), 0);
    repeat (4) step();

    // Randomised traffic including flush and reset pulses.
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 99) < 60);
        in_data  = DW'($urandom);
      end
      out_ready = ($urandom_range(0, 99) < 65);
      flush     = ($urandom_range(0, 99) < 3);
      reset     = ($urandom_range(0, 299) != 0);
    end
    step();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) step();
    @(negedge clk); #1;
    check("lit_final_count", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
